// File: rtl/alu_4b_reg_if.sv
// rtl/alu_4b_reg_if.sv - operand/opcode and registered result/flag bundle for alu_4b_reg
//
// Purpose: groups the ALU operand, opcode and registered result/status signals.
// Signals:
//   A, B     WIDTH  operands (unsigned / two's complement)
//   ALU_Sel  3      opcode
//   ALU_Out  WIDTH  registered result
//   carry    1      registered carry / borrow / shift-out
//   zero     1      registered, ALU_Out == 0
//   neg      1      registered, ALU_Out MSB
//   ovf      1      registered signed overflow
// Modports: master drives operands and opcode; slave (the ALU) drives the result and flags.
interface alu_4b_reg_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALU_Sel;
    logic [WIDTH-1:0] ALU_Out;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output A, B, ALU_Sel,
        input  ALU_Out, carry, zero, neg, ovf
    );

    modport slave (
        input  A, B, ALU_Sel,
        output ALU_Out, carry, zero, neg, ovf
    );
endinterface

// File: rtl/alu_4b_reg.sv
// rtl/alu_4b_reg.sv - registered WIDTH-bit ALU with carry/zero/neg/ovf status flags
//
// Purpose: combinational add/sub/and/or/xor/not/shl/shr datapath feeding a single
// output register stage, giving one result per clock at a latency of one cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; forces ALU_Out=0, zero=1, other flags 0
//   bus    alu_4b_reg_if.slave: A, B, ALU_Sel in; ALU_Out, carry, zero, neg, ovf out
module alu_4b_reg #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_4b_reg_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] res_next;
    logic             carry_next;
    logic             ovf_next;

    // One extra bit on each side so bit WIDTH holds the carry out of the add
    // and, for the subtract, the borrow (set exactly when A < B unsigned).
    assign sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
    assign diff_ext = {1'b0, bus.A} - {1'b0, bus.B};

    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        unique case (alu_op_e'(bus.ALU_Sel))
            OP_ADD: begin
                res_next   = sum_ext[WIDTH-1:0];
                carry_next = sum_ext[WIDTH];
                ovf_next   = (bus.A[MSB] == bus.B[MSB]) && (sum_ext[MSB] != bus.A[MSB]);
            end
            OP_SUB: begin
                res_next   = diff_ext[WIDTH-1:0];
                carry_next = diff_ext[WIDTH];
                ovf_next   = (bus.A[MSB] != bus.B[MSB]) && (diff_ext[MSB] != bus.A[MSB]);
            end
            OP_AND: res_next = bus.A & bus.B;
            OP_OR:  res_next = bus.A | bus.B;
            OP_XOR: res_next = bus.A ^ bus.B;
            OP_NOT: res_next = ~bus.A;
            OP_SHL: begin
                res_next   = {bus.A[WIDTH-2:0], 1'b0};
                carry_next = bus.A[MSB];
            end
            OP_SHR: begin
                res_next   = {1'b0, bus.A[WIDTH-1:1]};
                carry_next = bus.A[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ALU_Out <= '0;
            bus.carry   <= 1'b0;
            bus.zero    <= 1'b1;
            bus.neg     <= 1'b0;
            bus.ovf     <= 1'b0;
        end else begin
            bus.ALU_Out <= res_next;
            bus.carry   <= carry_next;
            bus.zero    <= (res_next == '0);
            bus.neg     <= res_next[MSB];
            bus.ovf     <= ovf_next;
        end
    end

endmodule

// File: tb/tb_alu_4b_reg.sv
// tb/tb_alu_4b_reg.sv - directed self-checking bench for alu_4b_reg
module tb_alu_4b_reg;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_4b_reg_if #(.WIDTH(4)) bus ();

    alu_4b_reg #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    // Observed value packed as {ALU_Out[3:0], carry, zero, neg, ovf}.
    function automatic logic [7:0] observed();
        return {bus.ALU_Out, bus.carry, bus.zero, bus.neg, bus.ovf};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got[7:0], exp[7:0]);
        end
    endtask

    // Drive between edges, then check one cycle later, #1 after the capturing edge.
    task automatic run_vec(input string tag, input logic [2:0] sel, input logic [3:0] a,
                           input logic [3:0] b, input logic [7:0] exp);
        @(negedge clk);
        bus.ALU_Sel = sel;
        bus.A       = a;
        bus.B       = b;
        @(posedge clk);
        #1;
        check_val(tag, {24'd0, observed()}, {24'd0, exp});
    endtask

    logic [3:0] b2b_res [8];
    logic [3:0] b2b_flg [8];

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.A       = 4'b0011;
        bus.B       = 4'b0001;
        bus.ALU_Sel = 3'b000;

        // Reset held low for two cycles; outputs must stay at reset values across an edge.
        @(posedge clk);
        #1;
        check_val("reset_hold", {24'd0, observed()}, {24'd0, 8'b0000_0100});
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //                                     {out, C Z N V}
        run_vec("add_3_1",   3'b000, 4'b0011, 4'b0001, 8'b0100_0000);
        run_vec("add_7_1",   3'b000, 4'b0111, 4'b0001, 8'b1000_0011);
        run_vec("add_f_1",   3'b000, 4'b1111, 4'b0001, 8'b0000_1100);
        run_vec("sub_6_2",   3'b001, 4'b0110, 4'b0010, 8'b0100_0000);
        run_vec("sub_2_6",   3'b001, 4'b0010, 4'b0110, 8'b1100_1010);
        run_vec("sub_8_1",   3'b001, 4'b1000, 4'b0001, 8'b0111_0001);
        run_vec("sub_5_5",   3'b001, 4'b0101, 4'b0101, 8'b0000_0100);
        run_vec("and",       3'b010, 4'b1100, 4'b1010, 8'b1000_0010);
        run_vec("or",        3'b011, 4'b1100, 4'b1010, 8'b1110_0010);
        run_vec("xor",       3'b100, 4'b1100, 4'b1010, 8'b0110_0000);
        run_vec("not",       3'b101, 4'b1100, 4'b1010, 8'b0011_0000);
        run_vec("shl_1001",  3'b110, 4'b1001, 4'b0000, 8'b0010_1000);
        run_vec("shr_1001",  3'b111, 4'b1001, 4'b0000, 8'b0100_1000);
        run_vec("shr_0001",  3'b111, 4'b0001, 4'b0000, 8'b0000_1100);
        run_vec("shl_0100",  3'b110, 4'b0100, 4'b0000, 8'b1000_0010);

        // Asynchronous reset between edges: result must clear with no clock edge.
        run_vec("pre_reset", 3'b000, 4'b0011, 4'b0001, 8'b0100_0000);
        rst_n = 1'b0;
        #1;
        check_val("async_reset", {24'd0, observed()}, {24'd0, 8'b0000_0100});
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back through all 8 opcodes with A=0110 B=0011.
        b2b_res[0] = 4'b1001; b2b_flg[0] = 4'b0011; // ADD 6+3=9: N, V
        b2b_res[1] = 4'b0011; b2b_flg[1] = 4'b0000; // SUB
        b2b_res[2] = 4'b0010; b2b_flg[2] = 4'b0000; // AND
        b2b_res[3] = 4'b0111; b2b_flg[3] = 4'b0000; // OR
        b2b_res[4] = 4'b0101; b2b_flg[4] = 4'b0000; // XOR
        b2b_res[5] = 4'b1001; b2b_flg[5] = 4'b0010; // NOT
        b2b_res[6] = 4'b1100; b2b_flg[6] = 4'b0010; // SHL
        b2b_res[7] = 4'b0011; b2b_flg[7] = 4'b0000; // SHR
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.ALU_Sel = 3'(i);
            bus.A       = 4'b0110;
            bus.B       = 4'b0011;
            #1;
            // Before the edge the previous result must still be held.
            if (i > 0)
                check_val($sformatf("b2b_hold_%0d", i), {28'd0, bus.ALU_Out}, {28'd0, b2b_res[i-1]});
            @(posedge clk);
            #1;
            check_val($sformatf("b2b_op_%0d", i), {24'd0, observed()}, {24'd0, b2b_res[i], b2b_flg[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
